// File: rtl/wr_dma_sched.sv
// wr_dma_sched: descriptor FIFO and burst scheduler driving an Avalon-MM write controller
module wr_dma_sched #(
    parameter int DESC_DEPTH = 4,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        wr_ctrl,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    output logic        irq
);
    localparam int          AW        = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam logic [AW:0] FULL      = (AW+1)'(DESC_DEPTH);
    localparam logic [31:0] MAX_BYTES = 32'(MAX_BURST * 4);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [31:0]   sb_q, sb_d, se_q, se_d, sd_q, sd_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d, bad_q, bad_d, tmo_q, tmo_d;
    logic [31:0]   cur_src_q, cur_src_d, cur_end_q, cur_end_d, cur_dst_q, cur_dst_d;
    logic [31:0]   chunk_q, chunk_d;
    logic [31:0]   pkt_begin_q, pkt_begin_d, pkt_end_q, pkt_end_d, waddr_q, waddr_d;
    logic          wr_ctrl_q, wr_ctrl_d;
    logic [15:0]   wcnt_q, wcnt_d, done_q, done_d;
    logic          irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   fifo_src_q [DESC_DEPTH];
    logic [31:0]   fifo_end_q [DESC_DEPTH];
    logic [31:0]   fifo_dst_q [DESC_DEPTH];
    logic [7:0]    wr_sel;
    logic [31:0]   len, rem;
    logic          flush, bad_push, push_ok, ovf_push, pop, tmo_set, done_evt;

    assign avs_readdata  = rdata_q;
    assign wr_ctrl       = wr_ctrl_q;
    assign control       = {30'd0, ctrl_q};
    assign pkt_begin     = pkt_begin_q;
    assign pkt_end       = pkt_end_q;
    assign write_address = waddr_q;
    assign irq           = irq_q;

    // Scheduler: pop a descriptor, issue bursts of up to MAX_BURST words, wait for each completion
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_end_d   = cur_end_q;
        cur_dst_d   = cur_dst_q;
        chunk_d     = chunk_q;
        pkt_begin_d = pkt_begin_q;
        pkt_end_d   = pkt_end_q;
        waddr_d     = waddr_q;
        wr_ctrl_d   = 1'b0;
        wcnt_d      = wcnt_q;
        pop         = 1'b0;
        tmo_set     = 1'b0;
        done_evt    = 1'b0;
        rem         = cur_end_q - cur_src_q;
        case (state_q)
            IDLE: state_d = (ctrl_q[0] && fill_q != '0) ? LOAD : IDLE;
            LOAD: begin
                pop       = fill_q != '0;
                cur_src_d = pop ? fifo_src_q[rptr_q] : cur_src_q;
                cur_end_d = pop ? fifo_end_q[rptr_q] : cur_end_q;
                cur_dst_d = pop ? fifo_dst_q[rptr_q] : cur_dst_q;
                state_d   = pop ? ISSUE : IDLE;
            end
            ISSUE: begin
                chunk_d     = (rem > MAX_BYTES) ? MAX_BYTES : rem;
                pkt_begin_d = cur_src_q;
                pkt_end_d   = cur_src_q + chunk_d;
                waddr_d     = cur_dst_q;
                wr_ctrl_d   = 1'b1;
                wcnt_d      = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (wcnt_q >= 16'd2 && wr_ctrl_rdy) begin
                    state_d = NEXT;
                end else if (wcnt_q == TO_LAST) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            NEXT: begin
                cur_src_d = cur_src_q + chunk_q;
                cur_dst_d = cur_dst_q + chunk_q;
                done_evt  = cur_src_d == cur_end_q;
                state_d   = done_evt ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    // CSR writes, push validation, FIFO pointers, sticky status and irq
    always_comb begin
        wr_sel   = avs_write ? (8'b1 << avs_address) : 8'b0;
        flush    = wr_sel[0] && avs_writedata[2];
        len      = se_q - sb_q;
        bad_push = wr_sel[4] && (len == '0 || len[1:0] != 2'b00 || se_q < sb_q);
        ovf_push = wr_sel[4] && !bad_push && fill_q == FULL && !pop;
        push_ok  = wr_sel[4] && !bad_push && !ovf_push;
        ctrl_d   = wr_sel[0] ? avs_writedata[1:0] : ctrl_q;
        sb_d     = wr_sel[1] ? avs_writedata : sb_q;
        se_d     = wr_sel[2] ? avs_writedata : se_q;
        sd_d     = wr_sel[3] ? avs_writedata : sd_q;
        fill_d   = flush ? '0 : fill_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        wptr_d   = flush ? '0 : wptr_q + AW'(push_ok);
        rptr_d   = flush ? '0 : rptr_q + AW'(pop);
        ovf_d    = ovf_push | (ovf_q & ~(wr_sel[5] & avs_writedata[9]));
        bad_d    = bad_push | (bad_q & ~(wr_sel[5] & avs_writedata[10]));
        tmo_d    = tmo_set | (tmo_q & ~(wr_sel[5] & avs_writedata[11]));
        done_d   = done_q + 16'(done_evt);
        irq_d    = (done_evt && ctrl_q[1]) || (irq_q && !wr_sel[6]);
    end

    // Registered read mux; data appears the cycle after the read strobe
    always_comb begin
        case (avs_address)
            3'd0:    rdata_d = control;
            3'd1:    rdata_d = sb_q;
            3'd2:    rdata_d = se_q;
            3'd3:    rdata_d = sd_q;
            3'd5:    rdata_d = {20'd0, tmo_q, bad_q, ovf_q, state_q != IDLE, 8'(fill_q)};
            3'd6:    rdata_d = {16'd0, done_q};
            default: rdata_d = '0;
        endcase
        rdata_d = avs_read ? rdata_d : '0;
    end

    // Descriptor storage; contents are only meaningful below the fill level, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_src_q[wptr_q] <= sb_q;
            fifo_end_q[wptr_q] <= se_q;
            fifo_dst_q[wptr_q] <= sd_q;
        end
    end

    // State register; reset abandons any burst in flight without counting it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            sb_q        <= '0;
            se_q        <= '0;
            sd_q        <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
            tmo_q       <= 1'b0;
            cur_src_q   <= '0;
            cur_end_q   <= '0;
            cur_dst_q   <= '0;
            chunk_q     <= '0;
            pkt_begin_q <= '0;
            pkt_end_q   <= '0;
            waddr_q     <= '0;
            wr_ctrl_q   <= 1'b0;
            wcnt_q      <= '0;
            done_q      <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            sb_q        <= sb_d;
            se_q        <= se_d;
            sd_q        <= sd_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            bad_q       <= bad_d;
            tmo_q       <= tmo_d;
            cur_src_q   <= cur_src_d;
            cur_end_q   <= cur_end_d;
            cur_dst_q   <= cur_dst_d;
            chunk_q     <= chunk_d;
            pkt_begin_q <= pkt_begin_d;
            pkt_end_q   <= pkt_end_d;
            waddr_q     <= waddr_d;
            wr_ctrl_q   <= wr_ctrl_d;
            wcnt_q      <= wcnt_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule

// File: tb/tb_wr_dma_sched.sv
// tb_wr_dma_sched: directed CSR/burst vectors with hand-computed expectations
module tb_wr_dma_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata, control, pkt_begin, pkt_end, write_address;
    logic        wr_ctrl, wr_ctrl_rdy, irq;
    int          nvec = 0, nerr = 0, pulses = 0, cyc = 0, mode = 0, cnt = 0;
    logic [31:0] rb [32];
    logic [31:0] re [32];
    logic [31:0] ra [32];
    int          pc [32];

    wr_dma_sched #(.DESC_DEPTH(4), .MAX_BURST(16), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy), .control(control),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end), .write_address(write_address), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start pulse with the burst it announced
    always @(negedge clk) begin
        if (wr_ctrl && pulses < 32) begin
            rb[pulses] = pkt_begin;
            re[pulses] = pkt_end;
            ra[pulses] = write_address;
            pc[pulses] = cyc;
        end
        if (wr_ctrl) pulses = pulses + 1;
    end

    // Write-controller model: mode 0 answers 5 cycles after a start, 1 holds ready high, 2 holds it low
    always @(negedge clk) begin
        if (mode != 0) begin
            wr_ctrl_rdy = (mode == 1);
        end else begin
            wr_ctrl_rdy = 1'b0;
            if (wr_ctrl) cnt = 5;
            else if (cnt != 0) begin
                cnt = cnt - 1;
                wr_ctrl_rdy = (cnt == 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] e, input logic [31:0] dst);
        wr(3'd1, b);
        wr(3'd2, e);
        wr(3'd3, dst);
        wr(3'd4, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            rd(3'd5, s);
            ok = (s[8] == 1'b0 && s[7:0] == 8'd0);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pkt_end", pkt_end, 32'd0);
        chk("rst_waddr", write_address, 32'd0);
        reset = 1'b1;
        rd(3'd5, v);  chk("rst_status", v, 32'd0);
        rd(3'd6, v);  chk("rst_done", v, 32'd0);

        // single short descriptor
        p0 = pulses;
        wr(3'd0, 32'd3);
        push(32'h100, 32'h140, 32'h2000);
        wait_idle("t1_idle");
        chk("t1_pulses", 32'(pulses - p0), 32'd1);
        chk("t1_begin", rb[p0], 32'h100);
        chk("t1_end", re[p0], 32'h140);
        chk("t1_addr", ra[p0], 32'h2000);
        chk("t1_end_held", pkt_end, 32'h140);
        rd(3'd6, v);  chk("t1_done", v, 32'd1);
        chk("t1_irq", 32'(irq), 32'd1);
        wr(3'd6, 32'd0);
        chk("t1_irq_clr", 32'(irq), 32'd0);

        // 36 words split into 16 + 16 + 4
        p0 = pulses;
        push(32'h1000, 32'h1090, 32'h2000);
        wait_idle("t2_idle");
        chk("t2_pulses", 32'(pulses - p0), 32'd3);
        chk("t2_end0", re[p0], 32'h1040);
        chk("t2_addr1", ra[p0 + 1], 32'h2040);
        chk("t2_begin1", rb[p0 + 1], 32'h1040);
        chk("t2_addr2", ra[p0 + 2], 32'h2080);
        chk("t2_end2", re[p0 + 2], 32'h1090);
        rd(3'd6, v);  chk("t2_done", v, 32'd2);

        // five pushes into a four-deep FIFO while disabled
        wr(3'd0, 32'd2);
        for (int i = 0; i < 5; i++) push(32'h0, 32'h10, 32'h3000);
        rd(3'd5, v);  chk("t3_status", v, 32'h204);
        wr(3'd5, 32'h200);
        rd(3'd5, v);  chk("t3_ovf_clr", v, 32'h004);
        p0 = pulses;
        wr(3'd0, 32'd3);
        wait_idle("t3_idle");
        chk("t3_pulses", 32'(pulses - p0), 32'd4);
        rd(3'd6, v);  chk("t3_done", v, 32'd6);

        // malformed descriptors
        p0 = pulses;
        push(32'h100, 32'h102, 32'h2000);
        push(32'h100, 32'h100, 32'h2000);
        rd(3'd5, v);  chk("t4_status", v, 32'h400);
        chk("t4_pulses", 32'(pulses - p0), 32'd0);
        wr(3'd5, 32'h400);
        rd(3'd5, v);  chk("t4_bad_clr", v, 32'd0);

        // flush empties the queue and does not stick in CTRL
        wr(3'd0, 32'd2);
        push(32'h0, 32'h10, 32'h3000);
        push(32'h0, 32'h10, 32'h3000);
        rd(3'd5, v);  chk("fl_fill", v, 32'h002);
        wr(3'd0, 32'h6);
        rd(3'd5, v);  chk("fl_status", v, 32'd0);
        rd(3'd0, v);  chk("fl_ctrl", v, 32'd2);
        chk("fl_control", control, 32'd2);

        // ready held high: guard keeps WAIT at three cycles or more
        mode = 1;
        p0 = pulses;
        wr(3'd0, 32'd3);
        push(32'h0, 32'h80, 32'h4000);
        wait_idle("t5_idle");
        chk("t5_pulses", 32'(pulses - p0), 32'd2);
        chk("t5_gap_ge5", 32'(pc[p0 + 1] - pc[p0] >= 5), 32'd1);
        chk("t5_addr1", ra[p0 + 1], 32'h4040);
        rd(3'd6, v);  chk("t5_done", v, 32'd7);

        // ready held low: abort after TIMEOUT cycles
        mode = 2;
        p0 = pulses;
        push(32'h0, 32'h40, 32'h4000);
        wait_idle("to_idle");
        chk("to_pulses", 32'(pulses - p0), 32'd1);
        rd(3'd5, v);  chk("to_status", v, 32'h800);
        rd(3'd6, v);  chk("to_done", v, 32'd7);
        wr(3'd5, 32'h800);

        // asynchronous reset while a burst is outstanding
        mode = 0;
        wr(3'd0, 32'd2);
        push(32'h0, 32'h100, 32'h5000);
        push(32'h0, 32'h100, 32'h5000);
        p0 = pulses;
        wr(3'd0, 32'd3);
        for (int i = 0; i < 60 && pulses == p0; i++) @(negedge clk);
        chk("t6_started", 32'(pulses - p0), 32'd1);
        @(negedge clk);
        chk("t6_pre_end", pkt_end, 32'h40);
        chk("t6_pre_irq", 32'(irq), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_wr_ctrl", 32'(wr_ctrl), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        chk("t6_begin", pkt_begin, 32'd0);
        chk("t6_end", pkt_end, 32'd0);
        chk("t6_addr", write_address, 32'd0);
        chk("t6_control", control, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(3'd5, v);  chk("t6_status", v, 32'd0);
        rd(3'd6, v);  chk("t6_done", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/wr_dma_sched.md
Name: wr_dma_sched

Overview:
Descriptor scheduler sequencing the Avalon-MM write controller datapath. Software queues copy descriptors (src begin, src end, dst address) through a small CSR slave. The block splits each descriptor into bursts of at most MAX_BURST words, drives the write controller's configuration and start inputs, and waits for each completion. It counts finished descriptors and raises a level interrupt.

Parameters:
DESC_DEPTH, 4, descriptor FIFO entries; power of 2, at least 2.
MAX_BURST, 16, maximum words per issued burst; 1 to 256.
TIMEOUT, 4096, maximum cycles in WAIT before abort; fits 16 bits.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
avs_address  in  3  CSR word index
avs_write  in  1  CSR write strobe
avs_writedata  in  32  CSR write data
avs_read  in  1  CSR read strobe
avs_readdata  out  32  CSR read data, 1-cycle latency
wr_ctrl  out  1  one-cycle start pulse to write controller
wr_ctrl_rdy  in  1  write controller done/ready
control  out  32  CTRL register value, forwarded to the datapath
pkt_begin  out  32  burst source begin (byte address)
pkt_end  out  32  burst source end (exclusive, byte address)
write_address  out  32  burst destination (byte address)
irq  out  1  level interrupt

Behaviour:
- Reset: all outputs, CSRs, FIFO pointers and counters go to 0; state goes to IDLE. Reset mid-burst aborts with no completion counted.
- CSR map:
  - 0 CTRL: bit0 enable, bit1 irq_en, bit2 flush (self-clearing).
  - 1 SRC_BEGIN, 2 SRC_END, 3 DST: staging registers.
  - 4 PUSH: any write enqueues the staged triple.
  - 5 STATUS (read-only): [7:0] fill level, bit8 busy, bit9 overflow, bit10 bad_desc, bit11 timeout. Bits 9-11 are sticky and are cleared by writing 1 to the same bit.
  - 6 DONE_CNT: [15:0] completion count. Any write clears irq.
  - 7 reads 0.
- PUSH validation: len = SRC_END - SRC_BEGIN, 32-bit unsigned.
  - len == 0, or len[1:0] != 0, or SRC_END < SRC_BEGIN: drop the push and set bad_desc.
  - FIFO full: drop the push and set overflow.
  - PUSH and pop in the same cycle: both take effect; fill is unchanged.
- FSM states IDLE, LOAD, ISSUE, WAIT, NEXT:
  - IDLE: if enable=1 and fill != 0, go to LOAD.
  - LOAD: pop the head; latch cur_src, cur_end, cur_dst; busy=1; go to ISSUE.
  - ISSUE: chunk = min((cur_end - cur_src)>>2, MAX_BURST). Register pkt_begin=cur_src, pkt_end=cur_src + 4*chunk, write_address=cur_dst. Pulse wr_ctrl=1 for exactly one cycle, in the same cycle those outputs update. Go to WAIT.
  - WAIT: ignore wr_ctrl_rdy for the first 2 cycles (stale-ready guard). Afterwards, wr_ctrl_rdy=1 goes to NEXT. If the wait counter reaches TIMEOUT: set timeout, drop the remainder of the descriptor (not counted), go to IDLE.
  - NEXT: cur_src += 4*chunk; cur_dst += 4*chunk.
    - If cur_src == cur_end: DONE_CNT++ (wraps at 16 bits), set irq if irq_en, go to IDLE.
    - Otherwise go to ISSUE.
- pkt_begin, pkt_end and write_address are held stable from ISSUE until the next ISSUE.
- control mirrors CTRL continuously.
- Clearing enable mid-descriptor: the current descriptor runs to completion, then the block stays in IDLE.
- Flush: empties the FIFO in the cycle it is written. It does not affect the descriptor in flight. Flush wins over a same-cycle PUSH.
- irq: a set event and a clearing write in the same cycle leave irq=1.
- busy=0 only in IDLE.
- Address arithmetic is 32-bit modulo. Wrap across 0xFFFFFFFF is undefined, and software must not request it.

Test Plan:
- Single short descriptor: begin=0x100, end=0x140, dst=0x2000, enable=1. Required: one ISSUE with pkt_end=0x140; rdy after 5 cycles; DONE_CNT=1; irq=1 when irq_en=1.
- Chunking: len=0x90 (36 words), MAX_BURST=16. Required: three bursts of 16, 16 and 4 words; write_address=0x2000, 0x2040, 0x2080; exactly 3 wr_ctrl pulses; DONE_CNT=1.
- FIFO full: push 5 descriptors with DESC_DEPTH=4 and enable=0. Required: fill=4 and overflow=1. After enable, exactly 4 completions.
- Bad descriptor: push with begin=0x100, end=0x102, then begin=0x100, end=0x100. Required: both dropped, fill=0, bad_desc=1.
- Stale ready and timeout: hold wr_ctrl_rdy=1 constantly. Required: WAIT still spans at least 3 cycles. With rdy held 0 and TIMEOUT=32: timeout=1, return to IDLE, DONE_CNT unchanged.
- Async reset: assert reset in WAIT mid-chunk. Required: wr_ctrl, irq and all outputs read 0 immediately; after release, FIFO empty and DONE_CNT=0.
